// File: rtl/arbitro_rr_c.sv
// Round-robin pop arbiter between four upstream class FIFOs and four downstream FIFOs.
// Pops one word, waits for it to appear, then pushes it to the FIFO selected by its destination field.
module arbitro_rr_c #(
    parameter int DW       = 6,
    parameter int DEST_LSB = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    fifo_empty_in,
    input  logic [3:0]    valid_in,
    input  logic [DW-1:0] data_in0,
    input  logic [DW-1:0] data_in1,
    input  logic [DW-1:0] data_in2,
    input  logic [DW-1:0] data_in3,
    input  logic [3:0]    almost_full_in,
    input  logic          error_in,
    output logic [3:0]    pop_out,
    output logic [3:0]    push_out,
    output logic [DW-1:0] data_out,
    output logic [1:0]    grant_out,
    output logic          idle_out,
    output logic          error_out
);

    typedef enum logic [5:0] {
        ST_RESET = 6'b000001,
        ST_IDLE  = 6'b000010,
        ST_POP   = 6'b000100,
        ST_WAIT  = 6'b001000,
        ST_PAUSE = 6'b010000,
        ST_ERROR = 6'b100000
    } state_t;

    state_t        state, state_next;
    logic [1:0]    ptr, ptr_next;
    logic [1:0]    grant_next;
    logic [3:0]    pop_next, push_next;
    logic [DW-1:0] data_next;
    logic [DW-1:0] word_sel;
    logic [1:0]    dest;
    logic [1:0]    cand, scan_idx;
    logic          cand_valid;

    // Scan from the highest offset down so the closest non-empty FIFO after ptr wins.
    always_comb begin
        cand       = 2'd0;
        cand_valid = 1'b0;
        scan_idx   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            scan_idx = ptr + 2'(k);
            if (!fifo_empty_in[scan_idx]) begin
                cand       = scan_idx;
                cand_valid = 1'b1;
            end
        end
    end

    always_comb begin
        word_sel = data_in0;
        case (grant_out)
            2'd0: word_sel = data_in0;
            2'd1: word_sel = data_in1;
            2'd2: word_sel = data_in2;
            2'd3: word_sel = data_in3;
            default: word_sel = data_in0;
        endcase
    end

    assign dest = word_sel[DEST_LSB+1:DEST_LSB];

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        grant_next = grant_out;
        pop_next   = 4'b0000;
        push_next  = 4'b0000;
        data_next  = data_out;
        case (state)
            ST_RESET: state_next = ST_IDLE;
            ST_IDLE: begin
                if (error_in) begin
                    state_next = ST_ERROR;
                end else if (|almost_full_in) begin
                    state_next = ST_PAUSE;
                end else if (cand_valid) begin
                    pop_next   = 4'b0001 << cand;
                    grant_next = cand;
                    state_next = ST_POP;
                end
            end
            ST_POP: begin
                state_next = error_in ? ST_ERROR : ST_WAIT;
            end
            // A word missing its valid is dropped; the pointer still advances past it.
            ST_WAIT: begin
                if (error_in) begin
                    state_next = ST_ERROR;
                end else begin
                    if (valid_in[grant_out]) begin
                        data_next = word_sel;
                        push_next = 4'b0001 << dest;
                    end
                    ptr_next   = grant_out + 2'd1;
                    state_next = ST_IDLE;
                end
            end
            ST_PAUSE: begin
                if (error_in) begin
                    state_next = ST_ERROR;
                end else if (almost_full_in == 4'b0000) begin
                    state_next = ST_IDLE;
                end
            end
            ST_ERROR: state_next = ST_ERROR;
            default:  state_next = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_RESET;
            ptr       <= 2'd0;
            grant_out <= 2'd0;
            pop_out   <= 4'b0000;
            push_out  <= 4'b0000;
            data_out  <= '0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            grant_out <= grant_next;
            pop_out   <= pop_next;
            push_out  <= push_next;
            data_out  <= data_next;
        end
    end

    assign idle_out  = (state == ST_IDLE) && (&fifo_empty_in);
    assign error_out = (state == ST_ERROR);

endmodule

// File: tb/tb_arbitro_rr_c.sv
// Bench for arbitro_rr_c: upstream FIFOs are modelled as queues, and a transaction-level
// reference predicts pops, pushes and flags every cycle; directed scenarios then random traffic.
module tb_arbitro_rr_c;

    localparam int DW       = 6;
    localparam int DEST_LSB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    fifo_empty_in;
    logic [3:0]    valid_in;
    logic [DW-1:0] data_arr [4];
    logic [3:0]    almost_full_in;
    logic          error_in;
    logic [3:0]    pop_out;
    logic [3:0]    push_out;
    logic [DW-1:0] data_out;
    logic [1:0]    grant_out;
    logic          idle_out;
    logic          error_out;

    always #5 clk = ~clk;

    arbitro_rr_c #(.DW(DW), .DEST_LSB(DEST_LSB)) dut (
        .clk            (clk),
        .reset          (reset),
        .fifo_empty_in  (fifo_empty_in),
        .valid_in       (valid_in),
        .data_in0       (data_arr[0]),
        .data_in1       (data_arr[1]),
        .data_in2       (data_arr[2]),
        .data_in3       (data_arr[3]),
        .almost_full_in (almost_full_in),
        .error_in       (error_in),
        .pop_out        (pop_out),
        .push_out       (push_out),
        .data_out       (data_out),
        .grant_out      (grant_out),
        .idle_out       (idle_out),
        .error_out      (error_out)
    );

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] fq [4][$];

    logic          rst_cmd    = 1'b0;
    logic          err_cmd    = 1'b0;
    logic [3:0]    af_cmd     = 4'b0000;
    logic          force_drop = 1'b0;
    logic          rand_drop  = 1'b0;

    // Reference model: transaction progress rather than an FSM encoding.
    logic          m_started  = 1'b0;
    logic          m_halted   = 1'b0;
    logic          m_paused   = 1'b0;
    int            m_inflight = 0;
    int            m_ptr      = 0;
    int            m_grant    = 0;
    logic [DW-1:0] m_word     = '0;
    logic          m_valid    = 1'b0;

    logic [3:0]    exp_pop   = 4'b0000;
    logic [3:0]    exp_push  = 4'b0000;
    logic [DW-1:0] exp_data  = '0;
    logic [1:0]    exp_grant = 2'd0;
    logic          exp_idle  = 1'b0;
    logic          exp_err   = 1'b0;

    task automatic checkValue(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic applyStimulus();
        logic drop;
        @(negedge clk);
        reset          = rst_cmd;
        error_in       = err_cmd;
        almost_full_in = af_cmd;
        for (int i = 0; i < 4; i++) begin
            fifo_empty_in[i] = (fq[i].size() == 0);
            data_arr[i]      = DW'($urandom);
        end
        valid_in = 4'($urandom);
        drop     = force_drop || (rand_drop && ($urandom_range(7) == 0));
        if (m_inflight == 2) begin
            valid_in[m_grant] = !drop;
            data_arr[m_grant] = m_word;
        end
        m_valid = valid_in[m_grant];
    endtask

    task automatic advanceModel();
        logic found;
        exp_pop  = 4'b0000;
        exp_push = 4'b0000;
        if (!reset) begin
            m_started  = 1'b0;
            m_halted   = 1'b0;
            m_paused   = 1'b0;
            m_inflight = 0;
            m_ptr      = 0;
            m_grant    = 0;
            exp_data   = '0;
        end else if (!m_started) begin
            m_started = 1'b1;
        end else if (m_halted) begin
            m_halted = 1'b1;
        end else if (error_in) begin
            m_halted   = 1'b1;
            m_inflight = 0;
        end else if (m_inflight == 1) begin
            m_inflight = 2;
        end else if (m_inflight == 2) begin
            if (m_valid) begin
                exp_data = m_word;
                exp_push = 4'b0001 << m_word[DEST_LSB+1:DEST_LSB];
            end
            m_ptr      = (m_grant + 1) % 4;
            m_inflight = 0;
        end else if (m_paused) begin
            if (almost_full_in == 4'b0000) m_paused = 1'b0;
        end else if (almost_full_in != 4'b0000) begin
            m_paused = 1'b1;
        end else begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_ptr + k) % 4;
                if (!found && fq[i].size() > 0) begin
                    found      = 1'b1;
                    m_grant    = i;
                    m_word     = fq[i].pop_front();
                    m_inflight = 1;
                    exp_pop    = 4'b0001 << i;
                end
            end
        end
        exp_grant = 2'(m_grant);
        exp_err   = m_halted;
        exp_idle  = m_started && !m_halted && !m_paused && (m_inflight == 0)
                    && (fifo_empty_in == 4'hF);
    endtask

    task automatic checkOutput();
        checkValue("pop_out",   8'(pop_out),   8'(exp_pop));
        checkValue("push_out",  8'(push_out),  8'(exp_push));
        checkValue("data_out",  8'(data_out),  8'(exp_data));
        checkValue("grant_out", 8'(grant_out), 8'(exp_grant));
        checkValue("idle_out",  8'(idle_out),  8'(exp_idle));
        checkValue("error_out", 8'(error_out), 8'(exp_err));
    endtask

    task automatic runCycle();
        applyStimulus();
        advanceModel();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic doReset();
        for (int i = 0; i < 4; i++) fq[i].delete();
        rst_cmd = 1'b0;
        runCycle();
        runCycle();
        checkValue("reset_pop",   8'(pop_out),   8'h00);
        checkValue("reset_push",  8'(push_out),  8'h00);
        checkValue("reset_data",  8'(data_out),  8'h00);
        checkValue("reset_error", 8'(error_out), 8'h00);
        rst_cmd = 1'b1;
        runCycle();
        checkValue("release_idle", 8'(idle_out), 8'h01);
    endtask

    task automatic randomTraffic(input int cycles);
        int af_hold;
        af_hold   = 0;
        rand_drop = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            if ($urandom_range(2) == 0) begin
                int q;
                q = $urandom_range(3);
                if (fq[q].size() < 8) fq[q].push_back(DW'($urandom));
            end
            if (af_hold > 0) begin
                af_hold--;
            end else if ($urandom_range(11) == 0) begin
                af_cmd  = 4'($urandom_range(15, 1));
                af_hold = $urandom_range(4, 1);
            end else begin
                af_cmd = 4'b0000;
            end
            rst_cmd = ($urandom_range(149) != 0);
            runCycle();
        end
        rst_cmd   = 1'b1;
        af_cmd    = 4'b0000;
        rand_drop = 1'b0;
    endtask

    initial begin
        reset          = 1'b0;
        error_in       = 1'b0;
        almost_full_in = 4'b0000;
        fifo_empty_in  = 4'hF;
        valid_in       = 4'b0000;
        for (int i = 0; i < 4; i++) data_arr[i] = '0;

        // Reset from an arbitrary mid-traffic state.
        doReset();
        randomTraffic(40);
        doReset();

        // Lone word in FIFO2 travels to downstream FIFO2 two cycles after its pop.
        fq[2].push_back(6'h25);
        runCycle();
        checkValue("lone_pop", 8'(pop_out), 8'h04);
        runCycle();
        runCycle();
        checkValue("lone_push", 8'(push_out), 8'h04);
        checkValue("lone_data", 8'(data_out), 8'h25);

        // All four busy: strict rotation, one pop every three cycles.
        doReset();
        fq[0].push_back(6'h01);
        fq[0].push_back(6'h12);
        fq[1].push_back(6'h23);
        fq[2].push_back(6'h34);
        fq[3].push_back(6'h05);
        for (int n = 0; n < 5; n++) begin
            runCycle();
            checkValue("rr_pop", 8'(pop_out), 8'(4'b0001 << (n % 4)));
            runCycle();
            runCycle();
        end

        // Backpressure raised mid-transaction: word still lands, then service stalls.
        doReset();
        fq[0].push_back(6'b01_0011);
        fq[1].push_back(6'b11_0001);
        runCycle();
        checkValue("af_pop0", 8'(pop_out), 8'h01);
        af_cmd = 4'b0010;
        runCycle();
        runCycle();
        checkValue("af_push", 8'(push_out), 8'h02);
        for (int n = 0; n < 3; n++) begin
            runCycle();
            checkValue("af_stall", 8'(pop_out), 8'h00);
        end
        af_cmd = 4'b0000;
        runCycle();
        runCycle();
        checkValue("af_resume", 8'(pop_out), 8'h02);
        runCycle();
        runCycle();

        // Missing valid drops the word and moves on to the next FIFO.
        doReset();
        fq[0].push_back(6'h11);
        fq[1].push_back(6'h32);
        runCycle();
        force_drop = 1'b1;
        runCycle();
        runCycle();
        force_drop = 1'b0;
        checkValue("drop_push", 8'(push_out), 8'h00);
        checkValue("drop_data", 8'(data_out), 8'h00);
        runCycle();
        checkValue("drop_next", 8'(pop_out), 8'h02);
        runCycle();
        runCycle();

        // Error during the wait cycle is sticky until reset.
        doReset();
        fq[0].push_back(6'h21);
        fq[1].push_back(6'h02);
        fq[2].push_back(6'h13);
        runCycle();
        runCycle();
        err_cmd = 1'b1;
        runCycle();
        err_cmd = 1'b0;
        checkValue("err_flag", 8'(error_out), 8'h01);
        checkValue("err_push", 8'(push_out), 8'h00);
        for (int n = 0; n < 4; n++) begin
            runCycle();
            checkValue("err_sticky", 8'(error_out), 8'h01);
            checkValue("err_nopop", 8'(pop_out), 8'h00);
        end
        rst_cmd = 1'b0;
        runCycle();
        checkValue("err_cleared", 8'(error_out), 8'h00);
        rst_cmd = 1'b1;
        runCycle();

        randomTraffic(600);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
